// File: rtl/bricks_pkg.sv
// Shared grid geometry, direction/state encodings and field-load helpers for brick_field.
package bricks_pkg;

  localparam int unsigned ROWS        = 12;
  localparam int unsigned COLS        = 16;
  localparam int unsigned CELLS       = ROWS * COLS;
  localparam int unsigned INIT_ROWS   = 4;
  localparam int unsigned INIT_BRICKS = INIT_ROWS * COLS;
  localparam int unsigned PADDLE_ROW  = 11;
  localparam logic [3:0]  PADDLE_HOME = 4'd6;

  typedef enum logic [1:0] {
    DIR_UP_RIGHT   = 2'b00,
    DIR_UP_LEFT    = 2'b01,
    DIR_DOWN_RIGHT = 2'b10,
    DIR_DOWN_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_e;

  // Brick pattern of a freshly loaded field: top INIT_ROWS rows full.
  function automatic logic [CELLS-1:0] load_map();
    logic [CELLS-1:0] m;
    for (int unsigned i = 0; i < CELLS; i++) m[i] = (i < INIT_BRICKS);
    return m;
  endfunction

  function automatic logic [CELLS-1:0] paddle_map(input logic [3:0] col, input int unsigned w);
    logic [CELLS-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < COLS; c++)
      if ((5'(c) >= 5'(col)) && (5'(c) < 5'(col) + 5'(w))) m[PADDLE_ROW*COLS + c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// Paddle position: prescaled step toward inc/dec, clamped to the grid.
module paddle_ctrl
  import bricks_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter int unsigned W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] col,
  output logic [3:0] col_nxt_c
);

  localparam logic [3:0] COL_MAX = 4'(COLS - W);

  logic [3:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt   = cnt;
    col_nxt_c = col;
    if (!reset) begin
      cnt_nxt   = '0;
      col_nxt_c = PADDLE_HOME;
    end else begin
      if (run) begin
        if (cnt == 4'(DIV - 1)) begin
          cnt_nxt = '0;
          if (inc && !dec && (col < COL_MAX)) col_nxt_c = col + 4'd1;
          else if (dec && !inc && (col != 4'd0)) col_nxt_c = col - 4'd1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      if (load) col_nxt_c = PADDLE_HOME;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
      col <= PADDLE_HOME;
    end else begin
      cnt <= cnt_nxt;
      col <= col_nxt_c;
    end
  end

endmodule

// File: rtl/brick_field.sv
// Brick map, ball hit/clear logic and game FSM. Optional score counter under BRICK_SCORE_EN.
module brick_field
  import bricks_pkg::*;
#(
  parameter int unsigned PADDLE_DIV = 4,
  parameter int unsigned PADDLE_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       Ball_rowIndex,
  input  logic [3:0]       Ball_colIndex,
  input  logic [1:0]       Ball_direction,
  input  logic             start,
  input  logic             paddle_inc,
  input  logic             paddle_dec,
  output logic [CELLS-1:0] data,
  output logic [1:0]       game_state,
  output logic             ball_run,
  output logic [6:0]       score
);

  state_e           state, state_nxt;
  logic [CELLS-1:0] bricks, bricks_nxt;
  logic [6:0]       count, count_nxt;
  logic             play_c, load_c, run_c;
  logic [3:0]       paddle_col, paddle_col_nxt;

  dir_e       dir;
  logic       down, col_up, under_paddle, miss_c;
  logic [5:0] vr, hc;
  logic       v_ok, h_ok, d_ok, v_hit, h_hit, d_hit;
  logic [7:0] v_idx, h_idx, d_idx;
  logic [1:0] n_clr;

  assign game_state = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PLAY;
      ST_PLAY: begin
        // An empty field wins even if the ball is missing the paddle this cycle.
        if (count == '0)  state_nxt = ST_WIN;
        else if (miss_c)  state_nxt = ST_LOSE;
      end
      ST_WIN, ST_LOSE: if (start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    play_c = 1'b0;
    load_c = 1'b0;
    run_c  = 1'b0;
    case (state)
      ST_IDLE: run_c = 1'b1;
      ST_PLAY: begin
        play_c = 1'b1;
        run_c  = 1'b1;
      end
      ST_WIN, ST_LOSE: load_c = start;
      default: ;
    endcase
  end

  // Neighbour cells V/H/D; negative coordinates wrap to 63 and fall out of range.
  always_comb begin
    dir          = dir_e'(Ball_direction);
    down         = (dir == DIR_DOWN_RIGHT) || (dir == DIR_DOWN_LEFT);
    col_up       = (dir == DIR_UP_LEFT) || (dir == DIR_DOWN_LEFT);
    vr           = 6'(Ball_rowIndex) + (down ? 6'd1 : 6'h3f);
    hc           = 6'(Ball_colIndex) + (col_up ? 6'd1 : 6'h3f);
    v_ok         = vr < 6'(PADDLE_ROW);
    h_ok         = (hc < 6'(COLS)) && (6'(Ball_rowIndex) < 6'(PADDLE_ROW));
    d_ok         = v_ok && (hc < 6'(COLS));
    v_idx        = {vr[3:0], Ball_colIndex};
    h_idx        = {Ball_rowIndex, hc[3:0]};
    d_idx        = {vr[3:0], hc[3:0]};
    v_hit        = v_ok && bricks[v_idx];
    h_hit        = h_ok && bricks[h_idx];
    d_hit        = d_ok && bricks[d_idx] && !v_hit && !h_hit;
    n_clr        = 2'(v_hit) + 2'(h_hit) + 2'(d_hit);
    under_paddle = (Ball_colIndex >= paddle_col) &&
                   (5'(Ball_colIndex) < 5'(paddle_col) + 5'(PADDLE_W));
    miss_c       = (Ball_rowIndex == 4'd10) && down && !under_paddle;
  end

  always_comb begin
    bricks_nxt = bricks;
    count_nxt  = count;
    if (load_c) begin
      bricks_nxt = load_map();
      count_nxt  = 7'(INIT_BRICKS);
    end else if (play_c) begin
      if (v_hit) bricks_nxt[v_idx] = 1'b0;
      if (h_hit) bricks_nxt[h_idx] = 1'b0;
      if (d_hit) bricks_nxt[d_idx] = 1'b0;
      count_nxt = count - 7'(n_clr);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bricks   <= load_map();
      count    <= 7'(INIT_BRICKS);
      data     <= load_map() | paddle_map(PADDLE_HOME, PADDLE_W);
      ball_run <= 1'b0;
    end else begin
      bricks   <= bricks_nxt;
      count    <= count_nxt;
      data     <= bricks_nxt | paddle_map(paddle_col_nxt, PADDLE_W);
      ball_run <= (state_nxt == ST_PLAY);
    end
  end

`ifdef BRICK_SCORE_EN
  logic [6:0] score_q;

  always_ff @(posedge clock) begin
    if (!reset)      score_q <= '0;
    else if (load_c) score_q <= '0;
    else if (play_c) score_q <= (score_q + 7'(n_clr) > 7'(INIT_BRICKS)) ? 7'(INIT_BRICKS)
                                                                        : score_q + 7'(n_clr);
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  paddle_ctrl #(
    .DIV (PADDLE_DIV),
    .W   (PADDLE_W)
  ) u_paddle (
    .clock     (clock),
    .reset     (reset),
    .run       (run_c),
    .load      (load_c),
    .inc       (paddle_inc),
    .dec       (paddle_dec),
    .col       (paddle_col),
    .col_nxt_c (paddle_col_nxt)
  );

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: reset, clears, win/lose, mid-play reset and paddle clamping.
module tb_brick_field;
  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   ball_row, ball_col;
  logic [1:0]   ball_dir;
  logic         start, paddle_inc, paddle_dec;
  logic [191:0] data;
  logic [1:0]   game_state;
  logic         ball_run;
  logic [6:0]   score;

  int errors = 0;
  int checks = 0;
  logic [191:0] load_pat;
  logic [63:0]  exp_bricks;

`ifdef BRICK_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  brick_field #(.PADDLE_DIV(4), .PADDLE_W(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .Ball_rowIndex  (ball_row),
    .Ball_colIndex  (ball_col),
    .Ball_direction (ball_dir),
    .start          (start),
    .paddle_inc     (paddle_inc),
    .paddle_dec     (paddle_dec),
    .data           (data),
    .game_state     (game_state),
    .ball_run       (ball_run),
    .score          (score)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ball(input int r, input int c, input int d);
    ball_row = 4'(r);
    ball_col = 4'(c);
    ball_dir = 2'(d);
  endtask

  function automatic logic [6:0] exp_score(input int n);
    return SCORE_ON ? 7'(n) : 7'd0;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (data[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_bricks got=%h exp=ffffffffffffffff", data[63:0]); end
    checks++; if (data !== load_pat) begin errors++; $display("FAIL reset_data got=%h exp=%h", data, load_pat); end
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", game_state); end
    checks++; if (ball_run !== 1'b0) begin errors++; $display("FAIL reset_ball_run got=%b exp=0", ball_run); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
  endtask

  task automatic test_idle_no_clear;
    ball(4, 5, 0);
    tick();
    checks++; if (data[53] !== 1'b1) begin errors++; $display("FAIL idle_no_clear got=%b exp=1", data[53]); end
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL idle_state got=%b exp=00", game_state); end
    ball(6, 8, 0);
  endtask

  task automatic test_clear_vertical;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL play_state got=%b exp=01", game_state); end
    checks++; if (ball_run !== 1'b1) begin errors++; $display("FAIL play_ball_run got=%b exp=1", ball_run); end
    ball(4, 5, 0);
    tick();
    ball(6, 8, 0);
    checks++; if (data[53] !== 1'b0) begin errors++; $display("FAIL vclear_bit53 got=%b exp=0", data[53]); end
    checks++; if (data[52] !== 1'b1) begin errors++; $display("FAIL vclear_diag52 got=%b exp=1", data[52]); end
    checks++; if (data[68] !== 1'b0) begin errors++; $display("FAIL vclear_bit68 got=%b exp=0", data[68]); end
    checks++; if (score !== exp_score(1)) begin errors++; $display("FAIL vclear_score got=%0d exp=%0d", score, exp_score(1)); end
    tick();
    checks++; if (score !== exp_score(1)) begin errors++; $display("FAIL idle_ball_score got=%0d exp=%0d", score, exp_score(1)); end
  endtask

  task automatic test_corner;
    ball(4, 6, 0);
    tick();
    checks++; if (data[54] !== 1'b0) begin errors++; $display("FAIL pre_corner_bit54 got=%b exp=0", data[54]); end
    ball(4, 6, 1);
    tick();
    ball(6, 8, 0);
    checks++; if (data[55] !== 1'b0) begin errors++; $display("FAIL corner_bit55 got=%b exp=0", data[55]); end
    checks++; if (data[56] !== 1'b1) begin errors++; $display("FAIL corner_bit56 got=%b exp=1", data[56]); end
    checks++; if (score !== exp_score(3)) begin errors++; $display("FAIL corner_score got=%0d exp=%0d", score, exp_score(3)); end
  endtask

  task automatic test_double;
    ball(3, 9, 0);
    tick();
    ball(6, 8, 0);
    checks++; if (data[41] !== 1'b0) begin errors++; $display("FAIL double_bit41 got=%b exp=0", data[41]); end
    checks++; if (data[56] !== 1'b0) begin errors++; $display("FAIL double_bit56 got=%b exp=0", data[56]); end
    checks++; if (data[40] !== 1'b1) begin errors++; $display("FAIL double_diag40 got=%b exp=1", data[40]); end
    checks++; if (score !== exp_score(5)) begin errors++; $display("FAIL double_score got=%0d exp=%0d", score, exp_score(5)); end
  endtask

  task automatic test_edges;
    exp_bricks = '1;
    exp_bricks[53] = 1'b0; exp_bricks[54] = 1'b0; exp_bricks[55] = 1'b0;
    exp_bricks[41] = 1'b0; exp_bricks[56] = 1'b0;
    ball(0, 0, 0);
    tick();
    ball(0, 15, 1);
    tick();
    checks++; if (data[63:0] !== exp_bricks) begin errors++; $display("FAIL corner_oob got=%h exp=%h", data[63:0], exp_bricks); end
    ball(10, 7, 2);
    tick();
    ball(6, 8, 0);
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL paddle_hit_state got=%b exp=01", game_state); end
    checks++; if (data[191:176] !== 16'h03C0) begin errors++; $display("FAIL paddle_row_kept got=%h exp=03c0", data[191:176]); end
    checks++; if (score !== exp_score(5)) begin errors++; $display("FAIL edges_score got=%0d exp=%0d", score, exp_score(5)); end
  endtask

  task automatic test_win;
    for (int r = 3; r >= 0; r--)
      for (int c = 0; c < 16; c++) begin
        ball(r + 1, c, 0);
        tick();
      end
    checks++; if (data[63:0] !== 64'h0) begin errors++; $display("FAIL win_field_empty got=%h exp=0", data[63:0]); end
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL win_still_play got=%b exp=01", game_state); end
    checks++; if (score !== exp_score(64)) begin errors++; $display("FAIL win_score got=%0d exp=%0d", score, exp_score(64)); end
    ball(10, 0, 2);
    tick();
    checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL win_over_miss got=%b exp=10", game_state); end
    checks++; if (ball_run !== 1'b0) begin errors++; $display("FAIL win_ball_run got=%b exp=0", ball_run); end
    tick(2);
    checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL win_hold got=%b exp=10", game_state); end
    ball(6, 8, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL win_restart_state got=%b exp=00", game_state); end
    checks++; if (data !== load_pat) begin errors++; $display("FAIL win_reload got=%h exp=%h", data, load_pat); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL win_reload_score got=%0d exp=0", score); end
  endtask

  task automatic test_lose;
    start = 1'b1;
    tick();
    start = 1'b0;
    ball(4, 5, 0);
    tick();
    checks++; if (score !== exp_score(1)) begin errors++; $display("FAIL lose_pre_score got=%0d exp=%0d", score, exp_score(1)); end
    ball(10, 9, 3);
    tick();
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL paddle_edge_hit got=%b exp=01", game_state); end
    ball(10, 10, 2);
    tick();
    checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL miss_lose got=%b exp=11", game_state); end
    checks++; if (ball_run !== 1'b0) begin errors++; $display("FAIL lose_ball_run got=%b exp=0", ball_run); end
    ball(4, 6, 0);
    tick();
    checks++; if (data[54] !== 1'b1) begin errors++; $display("FAIL lose_no_clear got=%b exp=1", data[54]); end
    ball(6, 8, 0);
    start = 1'b1;
    tick();
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL lose_restart got=%b exp=00", game_state); end
    checks++; if (data !== load_pat) begin errors++; $display("FAIL lose_reload got=%h exp=%h", data, load_pat); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL lose_reload_score got=%0d exp=0", score); end
    tick();
    start = 1'b0;
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL start_held_play got=%b exp=01", game_state); end
  endtask

  task automatic test_reset_mid_play;
    ball(4, 5, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ball(6, 8, 0);
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL midreset_state got=%b exp=00", game_state); end
    checks++; if (ball_run !== 1'b0) begin errors++; $display("FAIL midreset_ball_run got=%b exp=0", ball_run); end
    checks++; if (data !== load_pat) begin errors++; $display("FAIL midreset_data got=%h exp=%h", data, load_pat); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL midreset_score got=%0d exp=0", score); end
  endtask

  task automatic test_paddle;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    paddle_inc = 1'b1;
    tick(3);
    checks++; if (data[191:176] !== 16'h03C0) begin errors++; $display("FAIL paddle_prescale got=%h exp=03c0", data[191:176]); end
    tick();
    checks++; if (data[191:176] !== 16'h0780) begin errors++; $display("FAIL paddle_first_step got=%h exp=0780", data[191:176]); end
    tick(56);
    checks++; if (data[191:176] !== 16'hF000) begin errors++; $display("FAIL paddle_clamp_hi got=%h exp=f000", data[191:176]); end
    paddle_dec = 1'b1;
    tick(8);
    checks++; if (data[191:176] !== 16'hF000) begin errors++; $display("FAIL paddle_both_hold got=%h exp=f000", data[191:176]); end
    paddle_inc = 1'b0;
    tick(60);
    checks++; if (data[191:176] !== 16'h000F) begin errors++; $display("FAIL paddle_clamp_lo got=%h exp=000f", data[191:176]); end
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL paddle_idle_state got=%b exp=00", game_state); end
    paddle_dec = 1'b0;
  endtask

  initial begin
    load_pat = '0;
    load_pat[63:0] = '1;
    for (int c = 6; c < 10; c++) load_pat[176 + c] = 1'b1;
    reset = 1'b0;
    start = 1'b0;
    paddle_inc = 1'b0;
    paddle_dec = 1'b0;
    ball(6, 8, 0);
    #2;
    test_reset();
    test_idle_no_clear();
    test_clear_vertical();
    test_corner();
    test_double();
    test_edges();
    test_win();
    test_lose();
    test_reset_mid_play();
    test_paddle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
